// File: rtl/tx_interface.sv
`default_nettype none
// ============================================================================
// tx_interface : ALU result -> ASCII decimal frame ('R' [-] H T U LF) to uart_tx
// Rev 1.0
// ============================================================================
module tx_interface #(
  parameter int DBIT   = 8,
  parameter int SIGNED = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [DBIT-1:0] result,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [7:0]      tx_din,
  output logic            busy,
  output logic            done_tick
);

  localparam int              CW        = $clog2(DBIT + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(DBIT);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [DBIT-1:0] MAG_ONE   = DBIT'(1);
  localparam logic [2:0]      IDX_R     = 3'd0;
  localparam logic [2:0]      IDX_H     = 3'd2;
  localparam logic [2:0]      IDX_LF    = 3'd5;

  typedef enum logic [2:0] {IDLE, CONVERT, SEND, WAIT, DONE} state_t;

  state_t          state, state_nx;
  logic [DBIT-1:0] res_q;
  logic [DBIT-1:0] bin_q, bin_nx;
  logic [11:0]     bcd_q, bcd_nx, bcd_adj;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic [2:0]      idx_q, idx_nx;
  logic            neg_q, neg_nx, neg_calc;
  logic [DBIT-1:0] mag;
  logic [7:0]      din_nx;

  function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [11:0] bcd);
    case (idx)
      3'd0:    char_at = 8'd82;
      3'd1:    char_at = 8'd45;
      3'd2:    char_at = 8'd48 + {4'd0, bcd[11:8]};
      3'd3:    char_at = 8'd48 + {4'd0, bcd[7:4]};
      3'd4:    char_at = 8'd48 + {4'd0, bcd[3:0]};
      default: char_at = 8'd10;
    endcase
  endfunction

  // Magnitude taken in DBIT bits read as unsigned, so the most negative value maps to 2^(DBIT-1).
  assign neg_calc = (SIGNED != 0) && res_q[DBIT-1];
  assign mag      = neg_calc ? (~res_q + MAG_ONE) : res_q;

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      bcd_adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
    end
  end

  always_comb begin
    state_nx = state;
    bin_nx   = bin_q;
    bcd_nx   = bcd_q;
    cnt_nx   = cnt_q;
    idx_nx   = idx_q;
    neg_nx   = neg_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = CONVERT;
          cnt_nx   = '0;
        end
      end
      CONVERT: begin
        // Step 0 loads the magnitude; steps 1..DBIT are the double-dabble shifts.
        if (cnt_q == '0) begin
          bin_nx = mag;
          bcd_nx = '0;
          neg_nx = neg_calc;
        end else begin
          {bcd_nx, bin_nx} = {bcd_adj, bin_q} << 1;
        end
        if (cnt_q == LAST_STEP) begin
          state_nx = SEND;
          idx_nx   = IDX_R;
        end else begin
          cnt_nx = cnt_q + CNT_ONE;
        end
      end
      SEND: state_nx = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          if (idx_q == IDX_LF) begin
            state_nx = DONE;
          end else begin
            state_nx = SEND;
            idx_nx   = (idx_q == IDX_R && !neg_q) ? IDX_H : idx_q + 3'd1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    din_nx = char_at(idx_nx, bcd_nx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      res_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      neg_q     <= 1'b0;
      tx_start  <= 1'b0;
      tx_din    <= '0;
      busy      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      state <= state_nx;
      bin_q <= bin_nx;
      bcd_q <= bcd_nx;
      cnt_q <= cnt_nx;
      idx_q <= idx_nx;
      neg_q <= neg_nx;
      if (state == IDLE && start) begin
        res_q <= result;
      end
      // Outputs follow the next state so each one is a clean register.
      tx_start  <= (state_nx == SEND);
      busy      <= (state_nx == CONVERT) || (state_nx == SEND) || (state_nx == WAIT);
      done_tick <= (state_nx == DONE);
      if (state_nx == SEND) begin
        tx_din <= din_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_interface.sv
`default_nettype none
// ============================================================================
// tb_tx_interface : random + directed frames for signed and unsigned variants
// Rev 1.0
// ============================================================================
module tb_tx_interface;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] result = '0;
  logic       tx_done_tick = 1'b0;
  logic       mode = 1'b1;

  logic       tx_start_s, busy_s, done_s;
  logic       tx_start_u, busy_u, done_u;
  logic [7:0] tx_din_s, tx_din_u;
  logic       tx_start_m, busy_m, done_m;
  logic [7:0] tx_din_m;

  int total = 0;
  int bad   = 0;
  int n_txs = 0;
  int n_done = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  tx_interface #(.DBIT(8), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .start(start & mode), .result(result),
    .tx_done_tick(tx_done_tick & mode), .tx_start(tx_start_s), .tx_din(tx_din_s),
    .busy(busy_s), .done_tick(done_s)
  );

  tx_interface #(.DBIT(8), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset_n(reset_n), .start(start & ~mode), .result(result),
    .tx_done_tick(tx_done_tick & ~mode), .tx_start(tx_start_u), .tx_din(tx_din_u),
    .busy(busy_u), .done_tick(done_u)
  );

  assign tx_start_m = mode ? tx_start_s : tx_start_u;
  assign tx_din_m   = mode ? tx_din_s   : tx_din_u;
  assign busy_m     = mode ? busy_s     : busy_u;
  assign done_m     = mode ? done_s     : done_u;

  always @(negedge clk) begin
    if (tx_start_m === 1'b1) n_txs++;
    if (done_m === 1'b1) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference frame from the decimal value, independent of any conversion algorithm.
  function automatic void build_frame(input logic [7:0] r, input bit sgn);
    int v;
    v = int'(r);
    if (sgn && v > 127) v = v - 256;
    exp_q = {};
    exp_q.push_back(8'd82);
    if (v < 0) begin
      exp_q.push_back(8'd45);
      v = -v;
    end
    exp_q.push_back(8'(48 + v / 100));
    exp_q.push_back(8'(48 + (v / 10) % 10));
    exp_q.push_back(8'(48 + v % 10));
    exp_q.push_back(8'd10);
  endfunction

  task automatic wait_tx_start(input int limit, output int lat);
    lat = 0;
    while (tx_start_m !== 1'b1 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_frame(input logic [7:0] res, input bit sgn, input int gap, input bit noise);
    int lat;
    logic [7:0] held;
    bit stable_ok;
    mode = sgn;
    build_frame(res, sgn);
    stable_ok = 1'b1;
    @(negedge clk);
    n_txs = 0;
    n_done = 0;
    start = 1'b1;
    result = res;
    @(negedge clk);
    start = 1'b0;
    result = noise ? 8'h11 : 8'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 0) begin
        wait_tx_start(64, lat);
        check("first_lat", lat, 9);
        check("busy_mid", busy_m, 1);
      end else begin
        wait_tx_start(8, lat);
        check("byte_lat", lat, 0);
      end
      check("tx_din", tx_din_m, exp_q[i]);
      held = tx_din_m;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          result = 8'h11;
        end
        if (tx_din_m !== held || tx_start_m !== 1'b0) stable_ok = 1'b0;
      end
      start = 1'b0;
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
    end
    check("done_tick", done_m, 1);
    check("din_stable", stable_ok, 1);
    @(negedge clk);
    check("done_low", done_m, 0);
    check("busy_after", busy_m, 0);
    repeat (noise ? 30 : 3) @(negedge clk);
    check("n_tx_start", n_txs, exp_q.size());
    check("n_done", n_done, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start_m, 0);
    check("rst_tx_din", tx_din_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    reset_n = 1'b1;

    run_frame(8'd7,   1'b1, 20, 1'b0);
    run_frame(8'hFD,  1'b1, 20, 1'b0);
    run_frame(8'h80,  1'b1, 20, 1'b0);
    run_frame(8'hFF,  1'b0, 20, 1'b0);
    run_frame(8'h00,  1'b0, 20, 1'b0);
    run_frame(8'h9C,  1'b1, 5,  1'b1);

    // Abort in WAIT of the second byte.
    mode = 1'b1;
    @(negedge clk);
    start = 1'b1;
    result = 8'hF6;
    @(negedge clk);
    start = 1'b0;
    wait_tx_start(64, lat);
    check("abort_first", tx_din_m, 82);
    repeat (3) @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check("abort_second", tx_din_m, 45);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx_start", tx_start_m, 0);
    check("abort_busy", busy_m, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n_txs = 0;
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_stray", n_txs, 0);
    run_frame(8'hF6, 1'b1, 3, 1'b0);

    run_frame(8'd123, 1'b1, 1000, 1'b0);

    // Spurious completion while idle.
    n_txs = 0;
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_tick_tx", n_txs, 0);
    check("idle_tick_busy", busy_m, 0);

    for (int k = 0; k < 24; k++) begin
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 20),
                1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
